shared_bus_responder: RTL and testbench
=======================================

Name: shared_bus_responder

Overview:
- Responder end of the core memory bus: arbitrates `grant_request` from NUM_CORES cores and returns `grant_given` to one of them.
- Serves the owning core's byte reads and writes from an internal 512x8 memory.
- Sits between the core instances and main memory at top level.
- Round-robin fairness, with a forced-release limit on bus tenure.

Parameters:
- NUM_CORES, 2, number of initiator cores (1..8).
- ADDR_W, 9, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.
- MAX_BURST, 16, max granted access cycles before forced release when another core is waiting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- grant_request  in  NUM_CORES  per-core bus request.
- grant_given  out  NUM_CORES  per-core grant, one-hot or zero, registered.
- rw  in  NUM_CORES  per-core access type, 1=write, 0=read.
- address  in  NUM_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W].
- data_from_core  in  NUM_CORES*DATA_W  per-core write data (the core's data_out).
- data_to_core  out  DATA_W  read data broadcast to all cores (each core's data_in).
- owner_id  out  $clog2(NUM_CORES) max 1  index of current grant holder, 0 when idle.
- bus_busy  out  1  high while any grant_given bit is high.

Behaviour:
- Reset: sampled on rising clk while reset==0.
  - Outputs: grant_given=0, data_to_core=0, owner_id=0, bus_busy=0.
  - State: state=IDLE, rr_ptr=0, burst_cnt=0.
  - Memory contents are not cleared.
  - Reset mid-tenure drops the grant at that edge; an in-flight read result is discarded.
- States: IDLE, OWNED, RELEASE.
- IDLE:
  - If any grant_request bit is set, pick the first requester scanning from rr_ptr upward with wraparound.
  - Next edge: grant_given[w]=1, owner_id=w, burst_cnt=0, state=OWNED.
  - Request-to-grant latency is 1 cycle.
- OWNED, access cycle: a cycle with grant_given[o]=1 and grant_request[o]=1 is an access cycle.
  - rw[o]=1: mem[address_o] <= data_from_core_o at that edge.
  - rw[o]=0: data_to_core <= mem[address_o] at that edge, so read data is valid the cycle after the access (1-cycle latency).
  - burst_cnt increments per access cycle and saturates at MAX_BURST.
- OWNED, release:
  - If grant_request[o]=0, the cycle performs no access and data_to_core holds its value.
  - Next edge: grant_given=0, rr_ptr=(o+1) mod NUM_CORES, state=RELEASE.
- OWNED, forced release:
  - Condition: burst_cnt reaches MAX_BURST while another core's request is high.
  - That access completes; next edge grant_given=0 and state=RELEASE, rr_ptr as above.
  - A lone requester is never forced off.
- RELEASE:
  - One idle turnaround cycle, no grant; then IDLE.
  - A core's own rising grant_request while another core is granted waits.
  - Min gap between tenures is 2 cycles.
- Invariants:
  - At most one grant_given bit is high.
  - Inputs of non-owners are ignored.
  - Requests from cores without a grant are never dropped; they stay pending while held.
- Read-after-write at the same address on consecutive owner cycles returns the new data (write completes before the next read samples).
- The rw value of a non-access cycle is ignored.
- data_to_core changes only after a read access cycle.

Decomposition:
- Package bus_pkg:
  - ADDR_W/DATA_W defaults.
  - RW_READ=0, RW_WRITE=1.
  - typedef enum arb_state_t {IDLE, OWNED, RELEASE}.
  - typedef logic [ADDR_W-1:0] bus_addr_t, and bus_data_t.
- One sub-module bus_mem: single-port 2**ADDR_W x DATA_W RAM, synchronous write, registered read, write-enable and read-enable inputs.
- Arbiter FSM and round-robin pointer live in shared_bus_responder.

Test Plan:
- Single core, NUM_CORES=2: reset low 2 cycles, then core0 request → grant_given=2'b01 one cycle later.
  - Write 0x55 to addr 0x1A3, then read addr 0x1A3 → data_to_core=0x55 the cycle after the read.
- Contention: core0 and core1 request in the same cycle from reset → core0 granted first.
  - Core0 drops its request → grant 0, one RELEASE cycle, then grant_given=2'b10.
- Forced release: MAX_BURST=4, core0 holds request and core1 waits → after 4 accesses grant drops.
  - Core1 is granted 2 cycles later; core0 re-granted after core1 releases.
- Lone owner: core0 alone does 40 consecutive accesses with MAX_BURST=16 → grant never drops; all 40 writes to 0x000..0x027 read back correctly.
- Non-owner isolation: core1 drives rw=1, addr 0x010, data 0xFF without a grant while core0 reads 0x010 (preloaded 0x33) → data_to_core=0x33; mem[0x010] unchanged.
- Reset mid-tenure: reset=0 during core0 read → next cycle grant_given=0, data_to_core=0, bus_busy=0.
  - After reset deasserts, memory still holds the previously written 0x55 at 0x1A3.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the core memory bus responder
package bus_pkg;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 8;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    typedef enum logic [1:0] {IDLE, OWNED, RELEASE} arb_state_t;
    typedef logic [DEF_ADDR_W-1:0] bus_addr_t;
    typedef logic [DEF_DATA_W-1:0] bus_data_t;
endpackage

// File: rtl/bus_mem.sv
// bus_mem: single-port byte RAM with synchronous write and registered read port
module bus_mem
    import bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // read register only loads on a read access, otherwise holds the last result
    always_comb rdata_d = re ? mem_q[addr] : rdata_q;

    // memory array has no reset so contents survive a bus reset
    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    // read result is cleared by reset, discarding any in-flight read
    always_ff @(posedge clk) begin
        if (!reset) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/shared_bus_responder.sv
// shared_bus_responder: round-robin bus arbiter with tenure limit serving owner accesses to a shared RAM
module shared_bus_responder
    import bus_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int OW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        grant_request,
    output logic [NUM_CORES-1:0]        grant_given,
    input  logic [NUM_CORES-1:0]        rw,
    input  logic [NUM_CORES*ADDR_W-1:0] address,
    input  logic [NUM_CORES*DATA_W-1:0] data_from_core,
    output logic [DATA_W-1:0]           data_to_core,
    output logic [OW-1:0]               owner_id,
    output logic                        bus_busy
);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [OW-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner, next_ptr;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d, burst_inc;
    logic                 found, access, others_req, own_rw;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_wdata;
    int                   idx;

    assign own_rw     = rw[owner_q];
    assign own_addr   = address[int'(owner_q)*ADDR_W +: ADDR_W];
    assign own_wdata  = data_from_core[int'(owner_q)*DATA_W +: DATA_W];
    assign access     = (state_q == OWNED) && grant_request[owner_q];
    assign others_req = |(grant_request & ~grant_q);
    assign burst_inc  = (burst_cnt_q == BW'(MAX_BURST)) ? burst_cnt_q : burst_cnt_q + BW'(1);
    assign next_ptr   = (int'(owner_q) == NUM_CORES - 1) ? '0 : owner_q + OW'(1);

    // first requester at or after rr_ptr with wraparound; reverse scan lets the nearest one win
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_CORES;
            if (grant_request[idx]) begin
                winner = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    // arbiter next state: grant from IDLE, release on drop or tenure limit under contention
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d     = OWNED;
                grant_d     = NUM_CORES'(1) << winner;
                owner_d     = winner;
                burst_cnt_d = '0;
            end
        end else if (state_q == OWNED) begin
            burst_cnt_d = access ? burst_inc : burst_cnt_q;
            if (!access || (burst_inc == BW'(MAX_BURST) && others_req)) begin
                state_d  = RELEASE;
                grant_d  = '0;
                owner_d  = '0;
                rr_ptr_d = next_ptr;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // arbiter registers; grant and owner are driven straight from these flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    bus_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (reset && access && own_rw == RW_WRITE),
        .re    (reset && access && own_rw == RW_READ),
        .addr  (own_addr),
        .wdata (own_wdata),
        .rdata (data_to_core)
    );

    assign grant_given = grant_q;
    assign owner_id    = owner_q;
    assign bus_busy    = |grant_q;
endmodule

// File: tb/tb_shared_bus_responder.sv
// tb_shared_bus_responder: directed vectors, corner sequences and random traffic against a tenure-level model
module tb_shared_bus_responder;
    localparam int N  = 2;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MB = 4;

    typedef struct {
        logic [1:0]    req;
        logic          rw0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [1:0]    g;
        logic [DW-1:0] dout;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, rwv, grant;
    logic [AW-1:0]   addr_c [N];
    logic [DW-1:0]   wd_c [N];
    logic [N*AW-1:0] address;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   dout;
    logic            owner;
    logic            busy;
    int              n_checks = 0;
    int              n_pass = 0;

    int              m_own, m_wait, m_ptr, m_acc;
    logic [DW-1:0]   m_mem [512];
    bit              m_memv [512];
    logic [DW-1:0]   m_data;
    bit              m_dvalid;

    vec_t            tbl [7];
    logic [1:0]      fseq [13];

    assign address = {addr_c[1], addr_c[0]};
    assign wdata   = {wd_c[1], wd_c[0]};

    always #5 clk = ~clk;

    shared_bus_responder #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .grant_request  (req),
        .grant_given    (grant),
        .rw             (rwv),
        .address        (address),
        .data_from_core (wdata),
        .data_to_core   (dout),
        .owner_id       (owner),
        .bus_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // one bus cycle of the model: owner tenure, cooldown cycles, then round-robin pick
    function automatic void model_tick();
        bit rel;
        rel = 1'b0;
        if (!rst_n) begin
            m_own = -1; m_wait = 0; m_ptr = 0; m_acc = 0; m_data = '0; m_dvalid = 1'b1;
            return;
        end
        if (m_own >= 0) begin
            if (req[m_own]) begin
                if (rwv[m_own]) begin
                    m_mem[addr_c[m_own]]  = wd_c[m_own];
                    m_memv[addr_c[m_own]] = 1'b1;
                end else begin
                    m_data   = m_mem[addr_c[m_own]];
                    m_dvalid = m_memv[addr_c[m_own]];
                end
                m_acc++;
                rel = (m_acc >= MB) && ((req & ~(N'(1) << m_own)) != 0);
            end else rel = 1'b1;
            if (rel) begin
                m_ptr  = (m_own + 1) % N;
                m_own  = -1;
                m_wait = 1;
            end
        end else if (m_wait > 0) m_wait--;
        else for (int k = 0; k < N; k++)
            if (m_own < 0 && req[(m_ptr + k) % N]) begin
                m_own = (m_ptr + k) % N;
                m_acc = 0;
            end
    endfunction

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        check("model_grant", grant, (m_own < 0) ? 0 : (1 << m_own));
        check("model_owner", owner, (m_own < 0) ? 0 : m_own);
        check("model_busy", busy, m_own >= 0);
        if (m_dvalid) check("model_data", dout, m_data);
    endtask

    task automatic set0(input logic [1:0] r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req = r; rwv[0] = w; addr_c[0] = a; wd_c[0] = d;
    endtask

    task automatic set1(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rwv[1] = w; addr_c[1] = a; wd_c[1] = d;
    endtask

    task automatic expect_grant(input string name, input logic [1:0] g);
        check(name, grant, g);
        check({name, "_busy"}, busy, |g);
        check({name, "_owner"}, owner, g == 2'b10);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) m_memv[i] = 1'b0;
        m_own = -1; m_wait = 0; m_ptr = 0; m_acc = 0; m_data = '0; m_dvalid = 1'b0;
        rst_n = 1'b0;
        set0(2'b00, 1'b0, '0, '0);
        set1(1'b0, '0, '0);
        step();
        step();
        expect_grant("reset_grant", 2'b00);
        check("reset_data", dout, 8'h00);
        rst_n = 1'b1;

        tbl[0] = '{2'b01, 1'b0, 9'h000, 8'h00, 2'b01, 8'h00};
        tbl[1] = '{2'b01, 1'b1, 9'h1A3, 8'h55, 2'b01, 8'h00};
        tbl[2] = '{2'b01, 1'b0, 9'h1A3, 8'h00, 2'b01, 8'h55};
        tbl[3] = '{2'b01, 1'b1, 9'h0A3, 8'hAA, 2'b01, 8'h55};
        tbl[4] = '{2'b01, 1'b0, 9'h0A3, 8'h00, 2'b01, 8'hAA};
        tbl[5] = '{2'b00, 1'b0, 9'h000, 8'h00, 2'b00, 8'hAA};
        tbl[6] = '{2'b00, 1'b0, 9'h000, 8'h00, 2'b00, 8'hAA};
        for (int i = 0; i < 7; i++) begin
            set0(tbl[i].req, tbl[i].rw0, tbl[i].a0, tbl[i].d0);
            step();
            expect_grant($sformatf("vec%0d_grant", i), tbl[i].g);
            check($sformatf("vec%0d_data", i), dout, tbl[i].dout);
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set0(2'b11, 1'b0, 9'h1A3, 8'h00);
        set1(1'b1, 9'h030, 8'h77);
        step();
        expect_grant("cont_first", 2'b01);
        step();
        check("cont_read", dout, 8'h55);
        step();
        expect_grant("cont_hold", 2'b01);
        req = 2'b10;
        step();
        expect_grant("cont_release", 2'b00);
        step();
        expect_grant("cont_gap", 2'b00);
        step();
        expect_grant("cont_core1", 2'b10);
        step();
        expect_grant("cont_core1_acc", 2'b10);
        req = 2'b00;
        step();
        step();

        fseq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
                 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        set0(2'b11, 1'b1, 9'h040, 8'h11);
        set1(1'b1, 9'h041, 8'h22);
        for (int i = 0; i < 13; i++) begin
            step();
            expect_grant($sformatf("force%0d", i), fseq[i]);
        end
        req = 2'b00;
        set1(1'b0, '0, '0);
        step();
        step();

        set0(2'b01, 1'b0, '0, '0);
        step();
        expect_grant("lone_grant", 2'b01);
        for (int i = 0; i < 40; i++) begin
            set0(2'b01, 1'b1, AW'(i), DW'(i * 3 + 7));
            step();
            expect_grant($sformatf("lone_w%0d", i), 2'b01);
        end
        for (int i = 0; i < 40; i++) begin
            set0(2'b01, 1'b0, AW'(i), 8'h00);
            step();
            check($sformatf("lone_r%0d", i), dout, DW'(i * 3 + 7));
        end

        set0(2'b01, 1'b1, 9'h010, 8'h33);
        step();
        set1(1'b1, 9'h010, 8'hFF);
        set0(2'b01, 1'b0, 9'h010, 8'h00);
        step();
        check("iso_read", dout, 8'h33);
        step();
        check("iso_reread", dout, 8'h33);
        set1(1'b0, '0, '0);

        set0(2'b01, 1'b0, 9'h1A3, 8'h00);
        rst_n = 1'b0;
        step();
        expect_grant("midrst_grant", 2'b00);
        check("midrst_data", dout, 8'h00);
        rst_n = 1'b1;
        step();
        expect_grant("postrst_grant", 2'b01);
        step();
        check("postrst_mem", dout, 8'h55);
        req = 2'b00;
        step();
        step();

        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < N; k++) begin
                req[k]    = ($urandom_range(0, 3) != 0);
                rwv[k]    = 1'($urandom_range(0, 1));
                addr_c[k] = AW'($urandom_range(0, 31));
                wd_c[k]   = DW'($urandom_range(0, 255));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
